// File: rtl/send_drain_sched_pkg.sv
// Shared definitions for the send-buffer drain sequencer.
//   - sched_state_e : sequencer state encoding (IDLE/HDR/DATA/ERR)
//   - header field placement (payload length sits at the bottom of the header word)
//   - default widths / limits used as parameter defaults by the top
package send_drain_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } sched_state_e;

    // Payload length field: bufData[HDR_LEN_LSB +: LEN_W]
    localparam int unsigned HDR_LEN_LSB       = 0;

    localparam int unsigned SDS_DATA_W        = 256;
    localparam int unsigned SDS_LEN_W         = 16;
    localparam int unsigned SDS_MAX_WORDS     = 512;
    localparam int unsigned SDS_CREDITS       = 4;

endpackage

// File: rtl/send_drain_sched_credit_counter.sv
// Saturating packet-credit counter.
// Ports:
//   clock     in   clock, rising edge
//   reset     in   asynchronous active-low reset; count returns to MAX
//   inc_i     in   return one credit (ignored when already at MAX)
//   dec_i     in   consume one credit (ignored when already at zero)
//   count_o   out  current credit count
// inc_i and dec_i together leave the count unchanged.
module send_drain_sched_credit_counter #(
    parameter  int unsigned MAX = 4,
    localparam int unsigned CW  = $clog2(MAX + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != CW'(MAX))) begin
            count_d = count_q + CW'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= CW'(MAX);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/send_drain_sched.sv
// Drains completed packets from the send buffer head into the RDMA TX stream.
// Waits for a complete packet at the buffer head, forwards the header word
// (SOP) and its payload beats (EOP on the last) over a valid/ready stream,
// popping one buffer word per accepted beat. Packet starts are gated on
// RDMA transmit credits. An oversized length field drops the header and
// parks the sequencer in ERR until reset.
// Ports:
//   clock, reset           clock (rising edge), async active-low reset
//   enable                 allow new packet starts
//   bufReady, bufData      head slot complete / current head word
//   bufPop                 consume head word this cycle
//   txData, txValid        beat to RDMA and its valid
//   txSop, txEop           header beat / last beat markers
//   txReady                RDMA accepts beat
//   creditRet              one packet credit returned (pulse)
//   busy                   sequencer not idle
//   errLen                 sticky illegal-length flag
//   pktCount               packets fully sent (wrapping)
module send_drain_sched
    import send_drain_sched_pkg::*;
#(
    parameter int unsigned DATA_W    = SDS_DATA_W,
    parameter int unsigned LEN_W     = SDS_LEN_W,
    parameter int unsigned MAX_WORDS = SDS_MAX_WORDS,
    parameter int unsigned CREDITS   = SDS_CREDITS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              bufReady,
    input  logic [DATA_W-1:0] bufData,
    output logic              bufPop,
    output logic [DATA_W-1:0] txData,
    output logic              txValid,
    output logic              txSop,
    output logic              txEop,
    input  logic              txReady,
    input  logic              creditRet,
    output logic              busy,
    output logic              errLen,
    output logic [31:0]       pktCount
);

    localparam int unsigned REM_W  = $clog2(MAX_WORDS + 1);
    localparam int unsigned CRED_W = $clog2(CREDITS + 1);

    sched_state_e      state_q;
    logic [REM_W-1:0]  remaining_q;
    logic              errLen_q;
    logic [31:0]       pktCount_q;

    logic [LEN_W-1:0]  hdrLen;
    logic              lenBad;
    logic              lenZero;
    logic              accept;
    logic              dropPop;
    logic              startOk;
    logic              hdrAccept;
    logic [CRED_W-1:0] creditCnt;

    assign hdrLen  = bufData[HDR_LEN_LSB +: LEN_W];
    assign lenBad  = hdrLen > LEN_W'(MAX_WORDS);
    assign lenZero = (hdrLen == '0);

    // Stream controls are decoded from state; data passes straight through.
    always_comb begin
        txValid = 1'b0;
        txSop   = 1'b0;
        txEop   = 1'b0;
        dropPop = 1'b0;
        case (state_q)
            ST_HDR: begin
                txSop   = 1'b1;
                txValid = bufReady && !lenBad;
                txEop   = lenZero;
                // Oversized header is discarded without being offered.
                dropPop = bufReady && lenBad;
            end
            ST_DATA: begin
                txValid = bufReady;
                txEop   = (remaining_q == REM_W'(1));
            end
            default: ;
        endcase
    end

    assign accept    = txValid && txReady;
    assign bufPop    = accept || dropPop;
    assign txData    = bufData;
    assign busy      = (state_q != ST_IDLE);
    assign errLen    = errLen_q;
    assign pktCount  = pktCount_q;
    assign hdrAccept = accept && (state_q == ST_HDR);
    assign startOk   = enable && bufReady && (creditCnt != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            errLen_q    <= 1'b0;
            pktCount_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (startOk) begin
                        state_q <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (dropPop) begin
                        errLen_q <= 1'b1;
                        state_q  <= ST_ERR;
                    end else if (accept) begin
                        if (lenZero) begin
                            pktCount_q <= pktCount_q + 32'd1;
                            state_q    <= ST_IDLE;
                        end else begin
                            remaining_q <= hdrLen[REM_W-1:0];
                            state_q     <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        remaining_q <= remaining_q - REM_W'(1);
                        if (remaining_q == REM_W'(1)) begin
                            pktCount_q <= pktCount_q + 32'd1;
                            state_q    <= ST_IDLE;
                        end
                    end
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    send_drain_sched_credit_counter #(
        .MAX (CREDITS)
    ) u_credit (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (creditRet),
        .dec_i   (hdrAccept),
        .count_o (creditCnt)
    );

endmodule

// File: tb/tb_send_drain_sched.sv
// Bench for send_drain_sched: a queue models the send buffer, a beat
// scoreboard holds every packet's expected beats, and a credit count is
// kept from the credit rules.
module tb_send_drain_sched;

    localparam int DW = 256;
    localparam int LW = 16;
    localparam int MW = 512;
    localparam int CR = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          bufReady = 1'b0;
    logic [DW-1:0] bufData = '0;
    logic          bufPop;
    logic [DW-1:0] txData;
    logic          txValid;
    logic          txSop;
    logic          txEop;
    logic          txReady = 1'b0;
    logic          creditRet = 1'b0;
    logic          busy;
    logic          errLen;
    logic [31:0]   pktCount;

    always #5 clock = ~clock;

    send_drain_sched #(
        .DATA_W    (DW),
        .LEN_W     (LW),
        .MAX_WORDS (MW),
        .CREDITS   (CR)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .bufReady  (bufReady),
        .bufData   (bufData),
        .bufPop    (bufPop),
        .txData    (txData),
        .txValid   (txValid),
        .txSop     (txSop),
        .txEop     (txEop),
        .txReady   (txReady),
        .creditRet (creditRet),
        .busy      (busy),
        .errLen    (errLen),
        .pktCount  (pktCount)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } beat_t;

    logic [DW-1:0] bufq[$];
    beat_t         expq[$];
    int            mCredit;
    int            expPkt;

    int readyPct, enPct, retPct, bubblePct;
    bit readyToggle, forceRet, retOnSop, errMode;

    int cyc, firstV, lastV, nV, nAcc, nPop, nSopEop;
    bit            prevStall;
    logic [DW-1:0] prevData;

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic push_pkt(input int len);
        logic [DW-1:0] w;
        w = rnd_word();
        w[LW-1:0] = len[LW-1:0];
        bufq.push_back(w);
        expq.push_back('{w, 1'b1, (len == 0)});
        for (int i = 0; i < len; i++) begin
            w = rnd_word();
            bufq.push_back(w);
            expq.push_back('{w, 1'b0, (i == len - 1)});
        end
    endtask

    task automatic clear_stats();
        cyc = 0; firstV = -1; lastV = -1; nV = 0; nAcc = 0; nPop = 0; nSopEop = 0;
        prevStall = 1'b0;
    endtask

    // One clock: drive inputs just after the edge, sample before the next.
    task automatic cycle();
        bit    acc;
        bit    popPending;
        beat_t b;
        popPending = 1'b0;
        bufReady  = (bufq.size() > 0) && !($urandom_range(99) < bubblePct);
        bufData   = bufReady ? bufq[0] : rnd_word();
        txReady   = readyToggle ? ((cyc % 2) == 0) : ($urandom_range(99) < readyPct);
        enable    = $urandom_range(99) < enPct;
        creditRet = forceRet || ($urandom_range(99) < retPct);
        forceRet  = 1'b0;
        #2;
        if (retOnSop && txValid && txSop && txReady) begin
            creditRet = 1'b1;
            retOnSop  = 1'b0;
        end
        check("pktCount", pktCount, expPkt);
        acc = txValid && txReady;
        if (!errMode) check("pop_per_accept", bufPop, acc);
        if (!bufReady) check("valid_without_ready", txValid, 1'b0);
        if (prevStall && txValid) check("stall_hold", txData, prevData);
        prevStall = txValid && !txReady;
        prevData  = txData;
        if (acc) begin
            if (expq.size() == 0) begin
                check("unexpected_beat", 1'b1, 1'b0);
            end else begin
                b = expq.pop_front();
                check("data", txData, b.d);
                check("sop", txSop, b.sop);
                check("eop", txEop, b.eop);
                if (b.sop) begin
                    check("credit_avail", (mCredit > 0), 1'b1);
                    mCredit--;
                end
                if (b.eop) expPkt++;
            end
            if (txSop && txEop) nSopEop++;
        end
        if (creditRet && mCredit < CR) mCredit++;
        if (txValid) begin
            if (firstV < 0) firstV = cyc;
            lastV = cyc;
            nV++;
        end
        if (acc) nAcc++;
        if (bufPop) begin
            nPop++;
            popPending = 1'b1;
        end
        @(posedge clock);
        #1;
        if (popPending && bufq.size() > 0) void'(bufq.pop_front());
        creditRet = 1'b0;
        cyc++;
    endtask

    task automatic run_drain(input int maxc, input string tag);
        while (expq.size() > 0 && cyc < maxc) cycle();
        check({tag, "_drained"}, (expq.size() == 0), 1'b1);
    endtask

    // Assert reset (with whatever inputs are currently driven), check reset
    // values, then release just after a rising edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_txValid", txValid, 1'b0);
        check("rst_txSop", txSop, 1'b0);
        check("rst_txEop", txEop, 1'b0);
        check("rst_bufPop", bufPop, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_errLen", errLen, 1'b0);
        check("rst_pktCount", pktCount, 32'd0);
        bufq.delete();
        expq.delete();
        mCredit = CR; expPkt = 0;
        readyPct = 100; enPct = 100; retPct = 0; bubblePct = 0;
        readyToggle = 0; forceRet = 0; retOnSop = 0; errMode = 0;
        bufReady = 1'b0; enable = 1'b0; txReady = 1'b0; creditRet = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        clear_stats();
    endtask

    // Four packets go on a full credit pool; the fifth must wait.
    task automatic credit_probe(input string tag);
        int base;
        base = expPkt;
        readyPct = 100; enPct = 100; retPct = 0; bubblePct = 0; readyToggle = 0;
        for (int i = 0; i < 5; i++) push_pkt(1);
        clear_stats();
        while (expPkt < base + 4 && cyc < 60) cycle();
        check({tag, "_four_sent"}, expPkt - base, 4);
        clear_stats();
        repeat (6) cycle();
        check({tag, "_fifth_waits"}, nV, 0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int base;
        #1;
        do_reset();

        // L=3, ready held high: four consecutive beats, header one cycle after start.
        push_pkt(3);
        clear_stats();
        run_drain(20, "l3");
        check("l3_first", firstV, 1);
        check("l3_span", lastV - firstV + 1, 4);
        check("l3_valid", nV, 4);
        check("l3_pops", nPop, 4);
        check("l3_pkt", pktCount, 32'd1);

        // L=0: single SOP+EOP beat.
        push_pkt(0);
        clear_stats();
        run_drain(20, "l0");
        check("l0_valid", nV, 1);
        check("l0_sopeop", nSopEop, 1);
        check("l0_pops", nPop, 1);
        check("l0_pkt", pktCount, 32'd2);

        // L=5 with txReady alternating.
        readyToggle = 1;
        push_pkt(5);
        clear_stats();
        run_drain(40, "l5");
        check("l5_acc", nAcc, 6);
        check("l5_pops", nPop, 6);
        readyToggle = 0;

        // Over-return credits (must saturate), then exhaust them.
        retPct = 100;
        repeat (5) cycle();
        retPct = 0;
        credit_probe("cred");
        // Credit pulse releases the fifth; return coincides with its header accept.
        forceRet = 1; retOnSop = 1;
        clear_stats();
        repeat (3) cycle();
        check("ret_start_latency", firstV, 2);
        run_drain(20, "fifth");
        base = expPkt;
        push_pkt(0);
        push_pkt(0);
        clear_stats();
        repeat (8) cycle();
        check("coincident_ret", expPkt - base, 1);

        // Reset during DATA beat 2.
        do_reset();
        push_pkt(6);
        clear_stats();
        while (nAcc < 3 && cyc < 20) cycle();
        check("mid_reached", nAcc, 3);
        bufReady = 1'b1; bufData = bufq[0]; txReady = 1'b1; enable = 1'b1;
        #1;
        check("mid_busy_before", busy, 1'b1);
        do_reset();
        credit_probe("post_rst");

        // Largest legal length.
        do_reset();
        push_pkt(MW);
        clear_stats();
        run_drain(600, "max");
        check("max_valid", nV, MW + 1);
        check("max_span", lastV - firstV + 1, MW + 1);
        check("max_pkt", pktCount, 32'd1);

        // Illegal length: header dropped, sequencer parked.
        do_reset();
        errMode = 1;
        begin
            logic [DW-1:0] w;
            w = rnd_word();
            w[LW-1:0] = 16'(MW + 1);
            bufq.push_back(w);
        end
        push_pkt(1);
        expq.delete();
        clear_stats();
        repeat (12) cycle();
        check("err_valid", nV, 0);
        check("err_pops", nPop, 1);
        check("err_flag", errLen, 1'b1);
        check("err_busy", busy, 1'b1);
        enable = 1'b1;
        do_reset();

        // Randomized traffic.
        readyPct = 70; enPct = 80; retPct = 25; bubblePct = 10;
        for (int i = 0; i < 40; i++) push_pkt(($urandom_range(3) == 0) ? 0 : $urandom_range(12));
        clear_stats();
        run_drain(6000, "rand");
        check("rand_pkt", pktCount, 32'd40);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
